// File: rtl/pmp_pkg.sv
// Shared PMP definitions: XLEN encoding, A-field and access-type encodings,
// cfg bit positions, exception codes and the fault-code helper.
package pmp_pkg;

  // XLEN encoding; data/address width is 1 << (XLEN + 4)
  localparam int XLEN_64B = 2;

  // pmpcfg A-field encodings
  typedef enum logic [1:0] {
    A_OFF   = 2'b00,
    A_TOR   = 2'b01,
    A_NA4   = 2'b10,
    A_NAPOT = 2'b11
  } pmp_a_e;

  // access types; 2'b11 behaves like a load
  localparam logic [1:0] ACC_FETCH = 2'b00;
  localparam logic [1:0] ACC_LOAD  = 2'b01;
  localparam logic [1:0] ACC_STORE = 2'b10;

  localparam logic [1:0] PRIV_M = 2'b11;

  // pmpcfg bit positions
  localparam int CFG_R    = 0;
  localparam int CFG_W    = 1;
  localparam int CFG_X    = 2;
  localparam int CFG_A_LO = 3;
  localparam int CFG_A_HI = 4;
  localparam int CFG_L    = 7;

  // exception codes
  localparam logic [3:0] NO_E                 = 4'd0;
  localparam logic [3:0] E_INSTR_ACCESS_FAULT = 4'd1;
  localparam logic [3:0] E_LOAD_ACCESS_FAULT  = 4'd5;
  localparam logic [3:0] E_STORE_ACCESS_FAULT = 4'd7;

  localparam logic [5:0] NO_MATCH_IDX = 6'd63;

  // access-fault code for a given access type
  function automatic logic [3:0] fault_code(input logic [1:0] acc);
    case (acc)
      ACC_FETCH: return E_INSTR_ACCESS_FAULT;
      ACC_STORE: return E_STORE_ACCESS_FAULT;
      default:   return E_LOAD_ACCESS_FAULT;
    endcase
  endfunction

endpackage

// File: rtl/pmp_check_engine_if.sv
// Request/response bundle between the pipeline and the PMP check engine.
interface pmp_check_engine_if
  import pmp_pkg::*;
#(
  parameter int XLEN = XLEN_64B
);
  localparam int W = 1 << (XLEN + 4);

  logic         i_req_valid;
  logic         o_req_ready;
  logic [W-1:0] i_addr;
  logic [1:0]   i_size;
  logic [1:0]   i_acc_type;
  logic [1:0]   i_priv;
  logic         o_rsp_valid;
  logic         i_rsp_ready;
  logic         o_fault;
  logic [3:0]   o_exception_code;
  logic [5:0]   o_match_idx;

  modport slave (
    input  i_req_valid, i_addr, i_size, i_acc_type, i_priv, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_fault, o_exception_code, o_match_idx
  );

  modport master (
    output i_req_valid, i_addr, i_size, i_acc_type, i_priv, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_fault, o_exception_code, o_match_idx
  );

endinterface

// File: rtl/pmp_entry_match.sv
// Combinational region/permission check of one PMP entry against an access
// spanning byte addresses a..e. Bounds use 4 extra bits so an all-ones NAPOT
// region (size 2^(W+3)) and the <<2 of pmpaddr never overflow.
module pmp_entry_match
  import pmp_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [7:0]   cfg_i,
  input  logic [W-1:0] pmpaddr_i,
  input  logic [W-1:0] prev_pmpaddr_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] e_i,
  input  logic [1:0]   acc_type_i,
  output logic         match_o,
  output logic         partial_o,
  output logic         perm_ok_o
);
  localparam int WW = W + 4;

  pmp_a_e        mode;
  logic [W:0]    ones_probe;
  logic [W-1:0]  napot_mask;
  logic [WW-1:0] lo;
  logic [WW-1:0] hi;
  logic [WW-1:0] a_ext;
  logic [WW-1:0] e_ext;
  logic          region_ok;
  logic          a_in;
  logic          e_in;
  logic          unused_cfg;

  assign unused_cfg = ^cfg_i[7:5];
  assign mode       = pmp_a_e'(cfg_i[CFG_A_HI:CFG_A_LO]);

  // x ^ (x+1) sets the trailing ones plus the first zero; drop the lowest bit
  assign ones_probe = {1'b0, pmpaddr_i} ^ ({1'b0, pmpaddr_i} + (W+1)'(1));
  assign napot_mask = ones_probe[W:1];

  assign a_ext = WW'(a_i);
  assign e_ext = WW'(e_i);

  // region bounds [lo, hi) per addressing mode
  always_comb begin
    lo        = '0;
    hi        = '0;
    region_ok = 1'b0;
    case (mode)
      A_TOR: begin
        lo        = WW'({prev_pmpaddr_i, 2'b00});
        hi        = WW'({pmpaddr_i, 2'b00});
        region_ok = lo < hi;
      end
      A_NA4: begin
        lo        = WW'({pmpaddr_i, 2'b00});
        hi        = lo + WW'(4);
        region_ok = 1'b1;
      end
      A_NAPOT: begin
        lo        = WW'({pmpaddr_i & ~napot_mask, 2'b00});
        hi        = lo + WW'({napot_mask, 3'b111}) + WW'(1);
        region_ok = 1'b1;
      end
      default: begin
        region_ok = 1'b0;
      end
    endcase
  end

  assign a_in      = (a_ext >= lo) && (a_ext < hi);
  assign e_in      = (e_ext >= lo) && (e_ext < hi);
  assign match_o   = region_ok && (a_in || e_in);
  assign partial_o = match_o && (a_in ^ e_in);

  // permission bit required by the access type
  always_comb begin
    perm_ok_o = 1'b0;
    case (acc_type_i)
      ACC_FETCH: perm_ok_o = cfg_i[CFG_X];
      ACC_STORE: perm_ok_o = cfg_i[CFG_W];
      ACC_LOAD:  perm_ok_o = cfg_i[CFG_R];
      default:   perm_ok_o = cfg_i[CFG_R];
    endcase
  end

endmodule

// File: rtl/pmp_check_engine.sv
// Multi-cycle PMP checker: latches one request, spends one cycle forming the
// access end address, then scans LANES entries per cycle (lowest index wins)
// and holds the verdict until the consumer takes it. CSR writes during the
// scan restart it from entry 0 because CSR inputs are read live.
module pmp_check_engine
  import pmp_pkg::*;
#(
  parameter int XLEN        = XLEN_64B,
  parameter int NUM_ENTRIES = 16,
  parameter int LANES       = 4,
  localparam int W          = 1 << (XLEN + 4)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  pmp_check_engine_if.slave   bus,
  input  logic [64*W-1:0]     i_concat_pmpaddr,
  input  logic [511:0]        i_concat_pmpcfg,
  input  logic                i_pmp_csr_wr
);
  localparam int BASE_W = 7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic [BASE_W-1:0] base_q, base_d;
  logic              fault_q, fault_d;
  logic [3:0]        code_q, code_d;
  logic [5:0]        idx_q, idx_d;

  logic [W-1:0]      addr_q;
  logic [W-1:0]      end_q;
  logic [1:0]        size_q;
  logic [1:0]        acc_q;
  logic [1:0]        priv_q;
  logic              end_rdy_q;
  logic              wrap_q;
  logic [W:0]        end_sum;

  logic [W-1:0]      pmpaddr_arr [64];
  logic [7:0]        cfg_arr     [64];

  logic [LANES-1:0]  lane_match;
  logic [LANES-1:0]  lane_partial;
  logic [LANES-1:0]  lane_perm;
  logic [LANES-1:0]  lane_lock;
  logic [5:0]        lane_idx [LANES];

  logic              hit;
  logic              win_fault;
  logic [5:0]        win_idx;

  for (genvar i = 0; i < 64; i++) begin : g_unpack
    assign pmpaddr_arr[i] = i_concat_pmpaddr[i*W +: W];
    assign cfg_arr[i]     = i_concat_pmpcfg[i*8 +: 8];
  end

  assign end_sum = {1'b0, addr_q} + (W+1)'((4'd1 << size_q) - 4'd1);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [BASE_W-1:0] idx_full;
    logic              en;
    logic [7:0]        cfg_gated;
    logic [W-1:0]      prev_addr;

    assign idx_full    = base_q + BASE_W'(l);
    assign en          = idx_full < BASE_W'(NUM_ENTRIES);
    assign lane_idx[l] = idx_full[5:0];
    assign cfg_gated   = en ? cfg_arr[idx_full[5:0]] : 8'h00;
    assign prev_addr   = (idx_full[5:0] == 6'd0) ? '0 : pmpaddr_arr[idx_full[5:0] - 6'd1];
    assign lane_lock[l] = cfg_gated[CFG_L];

    pmp_entry_match #(.W(W)) u_match (
      .cfg_i          (cfg_gated),
      .pmpaddr_i      (pmpaddr_arr[idx_full[5:0]]),
      .prev_pmpaddr_i (prev_addr),
      .a_i            (addr_q),
      .e_i            (end_q),
      .acc_type_i     (acc_q),
      .match_o        (lane_match[l]),
      .partial_o      (lane_partial[l]),
      .perm_ok_o      (lane_perm[l])
    );
  end

  // pick the lowest-index matching lane and decide whether it faults
  always_comb begin
    hit       = 1'b0;
    win_fault = 1'b0;
    win_idx   = '0;
    for (int l = LANES - 1; l >= 0; l--) begin
      if (lane_match[l]) begin
        hit     = 1'b1;
        win_idx = lane_idx[l];
        if (lane_partial[l]) begin
          win_fault = 1'b1;
        end else if (priv_q == PRIV_M) begin
          win_fault = lane_lock[l] && !lane_perm[l];
        end else begin
          win_fault = !lane_perm[l];
        end
      end
    end
  end

  // next-state and result selection
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    fault_d = fault_q;
    code_d  = code_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (bus.i_req_valid) begin
          state_d = S_SCAN;
          base_d  = '0;
        end
      end
      S_SCAN: begin
        if (i_pmp_csr_wr) begin
          base_d = '0;
        end else if (!end_rdy_q) begin
          state_d = S_SCAN;
        end else if (wrap_q) begin
          state_d = S_RESP;
          fault_d = 1'b1;
          code_d  = fault_code(acc_q);
          idx_d   = NO_MATCH_IDX;
        end else if (hit) begin
          state_d = S_RESP;
          fault_d = win_fault;
          code_d  = win_fault ? fault_code(acc_q) : NO_E;
          idx_d   = win_idx;
        end else if (base_q + BASE_W'(LANES) >= BASE_W'(NUM_ENTRIES)) begin
          state_d = S_RESP;
          fault_d = (priv_q != PRIV_M);
          code_d  = (priv_q != PRIV_M) ? fault_code(acc_q) : NO_E;
          idx_d   = NO_MATCH_IDX;
        end else begin
          base_d = base_q + BASE_W'(LANES);
        end
      end
      S_RESP: begin
        if (bus.i_rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // control and result registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      fault_q <= 1'b0;
      code_q  <= NO_E;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      idx_q   <= idx_d;
    end
  end

  // request latch, then end address and wrap flag one cycle later
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      addr_q    <= '0;
      end_q     <= '0;
      size_q    <= '0;
      acc_q     <= '0;
      priv_q    <= '0;
      end_rdy_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else if (state_q == S_IDLE && bus.i_req_valid) begin
      addr_q    <= bus.i_addr;
      size_q    <= bus.i_size;
      acc_q     <= bus.i_acc_type;
      priv_q    <= bus.i_priv;
      end_rdy_q <= 1'b0;
    end else if (state_q == S_SCAN && !end_rdy_q) begin
      end_q     <= end_sum[W-1:0];
      wrap_q    <= end_sum[W];
      end_rdy_q <= 1'b1;
    end
  end

  assign bus.o_req_ready      = (state_q == S_IDLE);
  assign bus.o_rsp_valid      = (state_q == S_RESP);
  assign bus.o_fault          = fault_q;
  assign bus.o_exception_code = code_q;
  assign bus.o_match_idx      = idx_q;

endmodule
